mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter: LS_FIRST, 1, requester granted first after reset when both request (1=load/store, 0=fetch).
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 if_req  in  1  fetch request; held with if_addr until if_gnt.
REQ-005 if_addr  in  32  fetch byte address.
REQ-006 if_gnt / if_done  out  1 each  fetch grant pulse / completion pulse.
REQ-007 if_rdata  out  32  fetched word; valid from if_done, held until next fetch completion.
REQ-008 ls_req, ls_we  in  1 each  load/store request; 1=store.
REQ-009 ls_op  in  3  access size/extension; shared-header codes LW, LH, LHU, LB, LBU (stores use LW/LH/LB).
REQ-010 ls_addr, ls_wdata  in  32 each  byte address; store data, right-aligned.
REQ-011 ls_gnt / ls_done / ls_err  out  1 each  grant / completion / misalignment flag.
REQ-012 ls_rdata  out  32  extended load result; held until next load completion.
REQ-013 mem_en, mem_we  out  1 each; mem_be  out  4; mem_addr  out  32 ({addr[31:2],2'b00}); mem_wdata  out  32.
REQ-014 mem_rdata  in  32; mem_ready  in  1  access completes in any cycle where mem_en=1 and mem_ready=1.

Function
REQ-015 FSM states IDLE, ACCESS, RESP, ERR; one access in flight.
REQ-016 IDLE: one request -> its gnt high combinationally that cycle; both -> grant to requester not served last (round-robin); first tie after reset -> LS_FIRST.
REQ-017 On grant edge latch address, op, we, wdata, winner; go ACCESS (ERR per REQ-026).
REQ-018 ACCESS: mem_en=1 with latched fields; stay while mem_ready=0; mem_ready=1 -> capture formatted data, go RESP.
REQ-019 RESP: winner's done high exactly one cycle; return to IDLE; no grant issued in RESP.
REQ-020 Zero wait states: grant cycle N, mem_en cycle N+1, done cycle N+2; each extra mem_ready=0 cycle adds one.
REQ-021 Store byte enables: word 4'b1111; half addr[1]=0 4'b0011, =1 4'b1100; byte 4'b0001<<addr[1:0]; mem_wdata replicates low byte x4 / low half x2 / word.
REQ-022 Load LW: word unchanged; LB/LBU: byte at lane addr[1:0], sign/zero extended to 32; LH/LHU: half at addr[1], sign/zero extended.
REQ-023 Fetches always full word, mem_be=4'b1111, mem_we=0.
REQ-024 mem_en, mem_we, mem_be zero outside ACCESS; gnt/done never asserted for non-winner.
REQ-025 Request dropped before grant: no effect; request held after done: re-arbitrated in next IDLE cycle.

Reset
REQ-026 rst_n low: state IDLE, last-served = LS_FIRST pref, all gnt/done/err/mem_en/mem_we 0, mem_be 0, if_rdata/ls_rdata 32'h0; in-flight access abandoned, no done.

Configuration
REQ-027 ALIGN_CHECK_EN defined: granted LS with half at odd address or word at addr[1:0]!=0 -> ERR state, no mem_en, next cycle ls_done=1 and ls_err=1, ls_rdata unchanged, then IDLE.
REQ-028 ALIGN_CHECK_EN undefined: ls_err tied 0, no ERR state; half ignores addr[0], word ignores addr[1:0].

Verification
REQ-029 LB, ls_addr=0x102, mem_rdata=0x80FF7F01, mem_ready=1 -> mem_addr=0x100, ls_done at grant+2, ls_rdata=0xFFFFFFFF.
REQ-030 SH, ls_addr=0x206, ls_wdata=0x0000BEEF -> mem_we=1, mem_be=4'b1100, mem_wdata=0xBEEFBEEF.
REQ-031 if_req and ls_req held high 4 transactions, LS_FIRST=1 -> order LS, IF, LS, IF.
REQ-032 LW with mem_ready low 3 cycles -> mem_en high 4 cycles, ls_done at grant+5.
REQ-033 rst_n low mid-ACCESS -> mem_en 0 immediately, no done; next request served normally.
REQ-034 With ALIGN_CHECK_EN, LW at 0x101 -> no mem_en, ls_done=ls_err=1 at grant+1.

Source files
------------

// File: rtl/mem_ctrl.sv
// Single-port memory controller arbitrating instruction fetch and load/store traffic.
// Optional misalignment trap for load/store is enabled with `define ALIGN_CHECK_EN.
module mem_ctrl #(
    parameter bit LS_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [2:0]  ls_op,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_done,
    output logic        ls_err,
    output logic [31:0] ls_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [1:0]  dbg_state
);
    // Handshake: a requester holds req and its fields until gnt is seen high in a
    // cycle; the access is then owned by the controller and done pulses once.
    // ls_op[1:0] is the size (00 byte, 01 half, 10 word), ls_op[2] selects zero-extend.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
`ifdef ALIGN_CHECK_EN
        , ERR  = 2'd3
`endif
    } state_t;

    state_t      state, state_nxt;
    logic        last_ls;
    logic        lat_ls, lat_we;
    logic [2:0]  lat_op;
    logic [31:0] lat_addr, lat_wdata;
    logic        grant_ls, grant_if, err_c;
    logic [3:0]  be_c;
    logic [7:0]  byte_c;
    logic [15:0] half_c;
    logic [31:0] load_c;

    // Round-robin: on a tie the requester not served last wins.
    assign grant_ls = ls_req && (!if_req || !last_ls);
    assign grant_if = if_req && (!ls_req || last_ls);

`ifdef ALIGN_CHECK_EN
    logic misalign;
    assign misalign = (ls_op[1:0] == 2'b01 && ls_addr[0]) ||
                      (ls_op[1:0] == 2'b10 && ls_addr[1:0] != 2'b00);
    assign ls_err   = err_c;
`else
    assign ls_err   = 1'b0;
`endif

    always_comb begin
        be_c      = 4'b1111;
        mem_wdata = lat_wdata;
        case (lat_op[1:0])
            2'b00: begin
                be_c      = 4'b0001 << lat_addr[1:0];
                mem_wdata = {4{lat_wdata[7:0]}};
            end
            2'b01: begin
                be_c      = lat_addr[1] ? 4'b1100 : 4'b0011;
                mem_wdata = {2{lat_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (lat_addr[1:0])
            2'd0:    byte_c = mem_rdata[7:0];
            2'd1:    byte_c = mem_rdata[15:8];
            2'd2:    byte_c = mem_rdata[23:16];
            default: byte_c = mem_rdata[31:24];
        endcase
        half_c = lat_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (lat_op[1:0])
            2'b00:   load_c = {{24{~lat_op[2] & byte_c[7]}}, byte_c};
            2'b01:   load_c = {{16{~lat_op[2] & half_c[15]}}, half_c};
            default: load_c = mem_rdata;
        endcase
    end

    always_comb begin
        state_nxt = state;
        if_gnt    = 1'b0;
        ls_gnt    = 1'b0;
        if_done   = 1'b0;
        ls_done   = 1'b0;
        err_c     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        case (state)
            IDLE: begin
                if (grant_ls) begin
                    ls_gnt    = 1'b1;
`ifdef ALIGN_CHECK_EN
                    state_nxt = misalign ? ERR : ACCESS;
`else
                    state_nxt = ACCESS;
`endif
                end else if (grant_if) begin
                    if_gnt    = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                mem_en = 1'b1;
                mem_we = lat_ls & lat_we;
                mem_be = lat_ls ? be_c : 4'b1111;
                if (mem_ready) state_nxt = RESP;
            end
            RESP: begin
                ls_done   = lat_ls;
                if_done   = ~lat_ls;
                state_nxt = IDLE;
            end
`ifdef ALIGN_CHECK_EN
            ERR: begin
                ls_done   = 1'b1;
                err_c     = 1'b1;
                state_nxt = IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_ls   <= ~LS_FIRST;
            lat_ls    <= 1'b0;
            lat_we    <= 1'b0;
            lat_op    <= 3'b010;
            lat_addr  <= 32'h0;
            lat_wdata <= 32'h0;
            if_rdata  <= 32'h0;
            ls_rdata  <= 32'h0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && (grant_ls || grant_if)) begin
                last_ls  <= grant_ls;
                lat_ls   <= grant_ls;
                lat_addr <= grant_ls ? ls_addr : if_addr;
                lat_we   <= grant_ls & ls_we;
                lat_op   <= grant_ls ? ls_op : 3'b010;
                if (grant_ls) lat_wdata <= ls_wdata;
            end
            if (state == ACCESS && mem_ready) begin
                if (lat_ls && !lat_we) ls_rdata <= load_c;
                else if (!lat_ls)      if_rdata <= mem_rdata;
            end
        end
    end

    assign mem_addr  = {lat_addr[31:2], 2'b00};
    assign dbg_state = state;
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: drivers push expected completions, a monitor pops them.
module tb_mem_ctrl;
    localparam logic [2:0] OP_LB = 3'b000, OP_LH = 3'b001, OP_LW = 3'b010,
                           OP_LBU = 3'b100, OP_LHU = 3'b101;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0, mem_ready = 1'b0;
    logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0;
    logic [2:0]  ls_op = OP_LW;
    logic        if_gnt, if_done, ls_gnt, ls_done, ls_err, mem_en, mem_we;
    logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic [1:0]  dbg_state;

    logic        ovr_en = 1'b0;
    logic [31:0] ovr_data = '0;
    logic [31:0] ls_model = '0;
    logic [33:0] exp_q[$];
    logic [33:0] mon_act, mon_exp;
    int          n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    assign mem_rdata = ovr_en ? ovr_data : pat(mem_addr);

    mem_ctrl #(.LS_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_op(ls_op), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_done(ls_done), .ls_err(ls_err), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .dbg_state(dbg_state)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every completion must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && (if_done || ls_done)) begin
            check("done_onehot", 64'(if_done & ls_done), 64'(0));
            mon_act = {ls_done, ls_err, ls_done ? ls_rdata : if_rdata};
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got %0h expected none", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                check("completion", 64'(mon_act), 64'(mon_exp));
            end
        end
    end

    task automatic do_reset();
        rst_n  = 1'b0;
        if_req = 1'b0;
        ls_req = 1'b0;
        mem_ready = 1'b0;
        ls_model = '0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic do_ls(input logic we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] mdata, input int waits,
                         input logic [3:0] exp_be, input logic [31:0] exp_wd,
                         input logic [31:0] exp_ld);
        @(posedge clk); #1;
        ls_req = 1'b1; ls_we = we; ls_op = op; ls_addr = addr; ls_wdata = wdata;
        ovr_en = 1'b1; ovr_data = mdata; mem_ready = 1'b0;
        if (!we) ls_model = exp_ld;
        exp_q.push_back({1'b1, 1'b0, ls_model});
        @(negedge clk);
        check("ls_gnt", 64'(ls_gnt), 64'(1));
        check("mem_en_in_grant", 64'(mem_en), 64'(0));
        @(posedge clk); #1;
        ls_req = 1'b0;
        for (int w = 0; w <= waits; w++) begin
            mem_ready = (w == waits);
            @(negedge clk);
            check("mem_en", 64'(mem_en), 64'(1));
            check("ls_done_early", 64'(ls_done), 64'(0));
            if (w == 0) begin
                check("mem_addr", 64'(mem_addr), 64'({addr[31:2], 2'b00}));
                check("mem_we", 64'(mem_we), 64'(we));
                if (we) begin
                    check("mem_be", 64'(mem_be), 64'(exp_be));
                    check("mem_wdata", 64'(mem_wdata), 64'(exp_wd));
                end
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        @(negedge clk);
        check("ls_done", 64'(ls_done), 64'(1));
        check("mem_en_after", 64'(mem_en), 64'(0));
    endtask

    task automatic do_if(input logic [31:0] addr, input int waits);
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = addr; ovr_en = 1'b0; mem_ready = 1'b0;
        exp_q.push_back({1'b0, 1'b0, pat({addr[31:2], 2'b00})});
        @(negedge clk);
        check("if_gnt", 64'(if_gnt), 64'(1));
        @(posedge clk); #1;
        if_req = 1'b0;
        for (int w = 0; w <= waits; w++) begin
            mem_ready = (w == waits);
            @(negedge clk);
            check("if_mem_en", 64'(mem_en), 64'(1));
            check("if_mem_be", 64'(mem_be), 64'(4'b1111));
            check("if_mem_we", 64'(mem_we), 64'(0));
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        @(negedge clk);
        check("if_done", 64'(if_done), 64'(1));
    endtask

    initial begin
        do_reset();
        @(negedge clk);
        check("rst_state", 64'(dbg_state), 64'(0));
        check("rst_mem", 64'({mem_en, mem_we, mem_be}), 64'(0));
        check("rst_rdata", 64'({if_rdata, ls_rdata}), 64'(0));
        check("rst_handshake", 64'({if_gnt, if_done, ls_gnt, ls_done, ls_err}), 64'(0));

        // Both requesters held: LS first after reset, then alternate.
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h1000; ovr_en = 1'b0; mem_ready = 1'b1;
        ls_req = 1'b1; ls_we = 1'b0; ls_op = OP_LW; ls_addr = 32'h2000;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            check("rr_ls_gnt", 64'(ls_gnt), 64'(t % 2 == 0));
            check("rr_if_gnt", 64'(if_gnt), 64'(t % 2 == 1));
            if (t % 2 == 0) begin
                ls_model = pat(32'h2000);
                exp_q.push_back({1'b1, 1'b0, ls_model});
            end else begin
                exp_q.push_back({1'b0, 1'b0, pat(32'h1000)});
            end
            @(negedge clk);
            @(negedge clk);
            if (t == 3) begin
                if_req = 1'b0;
                ls_req = 1'b0;
                mem_ready = 1'b0;
            end
        end

        do_ls(1'b0, OP_LB,  32'h102, 32'h0, 32'h80FF7F01, 0, 4'h0, 32'h0, 32'hFFFFFFFF);
        do_ls(1'b0, OP_LBU, 32'h102, 32'h0, 32'h80FF7F01, 0, 4'h0, 32'h0, 32'h000000FF);
        do_ls(1'b0, OP_LH,  32'h102, 32'h0, 32'h80FF7F01, 0, 4'h0, 32'h0, 32'hFFFF80FF);
        do_ls(1'b0, OP_LHU, 32'h100, 32'h0, 32'h80FF7F01, 0, 4'h0, 32'h0, 32'h00007F01);
        do_ls(1'b0, OP_LB,  32'h101, 32'h0, 32'h80FF7F01, 0, 4'h0, 32'h0, 32'h0000007F);
        do_ls(1'b0, OP_LB,  32'h103, 32'h0, 32'h80FF7F01, 1, 4'h0, 32'h0, 32'hFFFFFF80);
        do_ls(1'b0, OP_LH,  32'h100, 32'h0, 32'h1234F00D, 0, 4'h0, 32'h0, 32'hFFFFF00D);
        do_ls(1'b1, OP_LH,  32'h206, 32'h0000BEEF, 32'h0, 0, 4'b1100, 32'hBEEFBEEF, 32'h0);
        do_ls(1'b1, OP_LB,  32'h203, 32'h12345678, 32'h0, 0, 4'b1000, 32'h78787878, 32'h0);
        do_ls(1'b1, OP_LW,  32'h200, 32'hCAFEF00D, 32'h0, 0, 4'b1111, 32'hCAFEF00D, 32'h0);
        do_ls(1'b1, OP_LH,  32'h204, 32'h00001234, 32'h0, 2, 4'b0011, 32'h12341234, 32'h0);
        do_ls(1'b0, OP_LW,  32'h300, 32'h0, 32'hDEADBEEF, 3, 4'h0, 32'h0, 32'hDEADBEEF);
        do_if(32'h4004, 2);
        do_if(32'h4008, 0);

`ifdef ALIGN_CHECK_EN
        @(posedge clk); #1;
        ls_req = 1'b1; ls_we = 1'b0; ls_op = OP_LW; ls_addr = 32'h101;
        exp_q.push_back({1'b1, 1'b1, ls_model});
        @(negedge clk);
        check("err_gnt", 64'(ls_gnt), 64'(1));
        @(posedge clk); #1;
        ls_req = 1'b0;
        @(negedge clk);
        check("err_no_mem_en", 64'(mem_en), 64'(0));
        check("err_done", 64'({ls_done, ls_err}), 64'(2'b11));
        @(negedge clk);
        check("err_back_idle", 64'({dbg_state, ls_done, ls_err}), 64'(0));
`else
        do_ls(1'b0, OP_LW, 32'h101, 32'h0, 32'h11223344, 0, 4'h0, 32'h0, 32'h11223344);
        do_ls(1'b0, OP_LH, 32'h103, 32'h0, 32'h11223344, 0, 4'h0, 32'h0, 32'h00001122);
`endif

        // Reset in the middle of an access abandons it silently.
        @(posedge clk); #1;
        ls_req = 1'b1; ls_we = 1'b0; ls_op = OP_LW; ls_addr = 32'h400; mem_ready = 1'b0;
        @(negedge clk);
        check("mid_gnt", 64'(ls_gnt), 64'(1));
        @(posedge clk); #1;
        ls_req = 1'b0;
        @(negedge clk);
        check("mid_mem_en", 64'(mem_en), 64'(1));
        rst_n = 1'b0;
        ls_model = '0;
        #1;
        check("mid_rst_mem_en", 64'(mem_en), 64'(0));
        check("mid_rst_state", 64'(dbg_state), 64'(0));
        check("mid_rst_rdata", 64'(ls_rdata), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_no_done", 64'({ls_done, if_done}), 64'(0));
        end
        do_ls(1'b0, OP_LHU, 32'h402, 32'h0, 32'hA5A5C3C3, 0, 4'h0, 32'h0, 32'h0000A5A5);

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
